// File: rtl/ripple_counter.sv
// Asynchronous ripple down counter built from WIDTH toggle flip-flops.
// Ports: clk (stage 0 clock), rst (async active-low clear), q (count, bit 0 = LSB).
module ripple_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] q
);

   genvar i;

   for (i = 0; i < WIDTH; i++) begin : g_stage
      logic stage_clk;
      logic bit_q;
      logic bit_d;

      // Stage i sees a rising edge on q[i-1] exactly when the lower bits
      // borrow (wrap 0 -> 1), which yields down-count order.
      if (i == 0) begin : g_first
         assign stage_clk = clk;
      end else begin : g_next
         assign stage_clk = q[i-1];
      end

      assign bit_d = ~bit_q;

      always_ff @(posedge stage_clk or negedge rst) begin
         if (!rst) begin
            bit_q <= 1'b0;
         end else begin
            bit_q <= bit_d;
         end
      end

      assign q[i] = bit_q;
   end

endmodule

// File: tb/tb_ripple_counter.sv
// Directed bench for ripple_counter: reset, count order, wrap,
// async reset mid-count, WIDTH=8, and a random-reset reference model.
module tb_ripple_counter;

   logic       clk;
   logic       rst;
   logic [3:0] q4;
   logic [7:0] q8;

   int n_cmp;
   int n_err;

   ripple_counter #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .q   (q4)
   );

   ripple_counter #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .q   (q8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      #1;
      n_cmp++;
      if (q4 !== 4'h0) begin
         n_err++;
         $display("FAIL reset_t1 q=%h expected=%h", q4, 4'h0);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (q4 !== 4'h0) begin
         n_err++;
         $display("FAIL reset_across_edge q=%h expected=%h", q4, 4'h0);
      end
      n_cmp++;
      if (q8 !== 8'h00) begin
         n_err++;
         $display("FAIL reset_across_edge_w8 q=%h expected=%h", q8, 8'h00);
      end
      #4;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (q4 !== 4'h0) begin
         n_err++;
         $display("FAIL reset_release_hold q=%h expected=%h", q4, 4'h0);
      end
   endtask

   task automatic test_full_sequence();
      logic [3:0] exp4;
      logic [7:0] exp8;
      for (int n = 1; n <= 17; n++) begin
         @(negedge clk);
         exp4 = 4'((16 - n) & 15);
         exp8 = 8'((256 - n) & 255);
         n_cmp++;
         if (q4 !== exp4) begin
            n_err++;
            $display("FAIL seq_edge%0d q=%h expected=%h", n, q4, exp4);
         end
         n_cmp++;
         if (q8 !== exp8) begin
            n_err++;
            $display("FAIL seq_w8_edge%0d q=%h expected=%h", n, q8, exp8);
         end
      end
   endtask

   task automatic test_async_mid();
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
      end
      n_cmp++;
      if (q4 !== 4'hB) begin
         n_err++;
         $display("FAIL async_precount q=%h expected=%h", q4, 4'hB);
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (q4 !== 4'h0) begin
         n_err++;
         $display("FAIL async_clear q=%h expected=%h", q4, 4'h0);
      end
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         n_cmp++;
         if (q4 !== 4'h0) begin
            n_err++;
            $display("FAIL async_hold%0d q=%h expected=%h", n, q4, 4'h0);
         end
      end
   endtask

   task automatic test_width8();
      logic [7:0] exp_tab [3];
      exp_tab[0] = 8'hFF;
      exp_tab[1] = 8'hFE;
      exp_tab[2] = 8'hFD;
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (q8 !== 8'h00) begin
         n_err++;
         $display("FAIL w8_reset q=%h expected=%h", q8, 8'h00);
      end
      @(negedge clk);
      #1;
      rst = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         n_cmp++;
         if (q8 !== exp_tab[n]) begin
            n_err++;
            $display("FAIL w8_edge%0d q=%h expected=%h", n + 1, q8,
                     exp_tab[n]);
         end
      end
   endtask

   task automatic test_random_model();
      logic [3:0] m4;
      logic [7:0] m8;
      m4 = 4'h0;
      m8 = 8'h00;
      @(negedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         n_cmp++;
         if (q4 !== m4) begin
            n_err++;
            $display("FAIL model4_cyc%0d q=%h expected=%h", c, q4, m4);
         end
         n_cmp++;
         if (q8 !== m8) begin
            n_err++;
            $display("FAIL model8_cyc%0d q=%h expected=%h", c, q8, m8);
         end
         #1;
         rst = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
         if (!rst) begin
            m4 = 4'h0;
            m8 = 8'h00;
         end
         @(posedge clk);
         if (rst) begin
            m4 = m4 - 4'h1;
            m8 = m8 - 8'h01;
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      test_reset();
      test_full_sequence();
      test_async_mid();
      test_width8();
      test_random_model();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ripple_counter.md
RIPPLE_COUNTER -- requirements
Module: ripple_counter

Interface
REQ-001 Parameter: WIDTH, default 4, number of counter stages and width of q.
REQ-002 Port: clk  input  1  counter clock; stage 0 is triggered on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset; 0 clears all stages immediately.
REQ-004 Port: q  output  WIDTH  current count value; bit 0 is the LSB.
REQ-005 The block SHALL have one clock (clk) and one asynchronous active-low reset (rst), with no other inputs.

Function
REQ-006 The block SHALL be a binary down counter that decrements by 1 on every rising clk edge while rst=1.
REQ-007 The counter SHALL use ripple structure: WIDTH toggle flip-flops, each holding one bit of q.
REQ-008 Stage 0 SHALL toggle on each rising edge of clk.
REQ-009 Stage i (i>=1) SHALL toggle on each rising edge of q[i-1], which gives down-count order.
REQ-010 Stage i SHALL NOT be clocked by clk or by any combinational decode.
REQ-011 Wrap-around: from all-zeros, the next edge SHALL produce all-ones (4'b0000 -> 4'b1111), with no flag and no stall.
REQ-012 Modular count: after N rising clk edges from 0, q SHALL equal (2^WIDTH - N) mod 2^WIDTH.
REQ-013 Settling: q SHALL reach its final value no later than WIDTH stage-delays after the clk edge.
REQ-014 Transient intermediate codes on q during ripple are permitted and are not errors.
REQ-015 q SHALL be stable and correct before the next rising clk edge.
REQ-016 In zero-delay simulation, q SHALL settle within the same timestep as the clk edge.
REQ-017 The counter SHALL ignore falling clk edges.
REQ-018 q SHALL be driven directly from the flip-flop outputs, with no output register and no added latency.

Reset
REQ-019 When rst=0, every stage SHALL clear to 0 asynchronously, so q=0 regardless of clk.
REQ-020 While rst=0, q SHALL remain 0 and clk edges SHALL have no effect.
REQ-021 Reset asserted mid-ripple SHALL override any pending toggles in all stages.
REQ-022 On rst deassertion (0->1), q SHALL remain 0 until the first subsequent rising clk edge.
REQ-023 That first rising edge SHALL produce q = all-ones.
REQ-024 Reset deassertion coincident with a clk rising edge SHALL NOT cause a count on that edge.
REQ-025 Reset deassertion coincident with a clk rising edge SHALL produce no X state on q.
REQ-026 Power-up contents before the first reset are undefined; the bench SHALL apply reset first.

Verification
REQ-027 Reset hold: clk period 10, rst=0 for 10 time units -> q=0000 throughout, including across the clk edge at t=5.
REQ-028 First count: rst 0->1 at t=10 -> q=0000 at t=10, then q=1111 after the edge at t=15, then q=1110 at t=25.
REQ-029 Full-sequence and wrap checks:
- 16 rising edges after reset release -> q steps 1111, 1110, ..., 0001, 0000.
- The 17th edge -> q=1111 (wrap).
- q checked at every falling edge.
REQ-030 Async reset mid-count: count to q=1011, drive rst=0 midway between edges -> q=0000 immediately without waiting for a clk edge; q holds 0000 over 3 further edges.
REQ-031 Parameter check: WIDTH=8, release reset, apply 3 edges -> q=8'hFF, 8'hFE, 8'hFD.
REQ-032 Reference-model check: random reset pulses over 200 cycles -> q matches a modular down-count model at every falling clk edge.
